timer_disp_sel: RTL
===================

# timer_disp_sel

Parametrised N-channel display selector for the stopwatch/timer datapath. It chooses one of NCH (secs, mins) channel pairs for the shared display and drives one active-low indicator LED per channel. Display sources, in priority order: a forced hold channel, an automatic round-robin scan, then the direct select lines. Outputs are registered and can be frozen for lap display. It sits between the per-channel timer counters and the display driver.

## Interface
- NCH, 4: number of timer channels; at least 2.
- W, 8: width of each secs and mins field.
- SCAN_TICKS, 4: clock cycles each channel is shown in scan mode; at least 1.
- CHW, derived: $clog2(NCH), width of channel index ports.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- secs_in  in  NCH*W  channel k secs at bits [k*W +: W].
- mins_in  in  NCH*W  channel k mins at bits [k*W +: W].
- sel  in  NCH  direct select, one bit per channel.
- hold  in  1  force display of channel hold_ch.
- hold_ch  in  CHW  channel index used while hold=1.
- scan_en  in  1  enable round-robin scan.
- freeze  in  1  keep all display outputs at their current values.
- secs  out  W  displayed secs, registered.
- mins  out  W  displayed mins, registered.
- led  out  NCH  active-low one-hot marking the displayed channel; all ones when blank.
- cur_ch  out  CHW  index of the displayed channel; 0 when blank.
- valid  out  1  1 when a channel is displayed, 0 when blank.

## Operation
- **Next-channel choice (combinational, by priority):**
  - If hold=1: use hold_ch when hold_ch < NCH. If hold_ch >= NCH, the display is blank.
  - Else if scan_en=1: use scan_idx.
  - Else if sel != 0: use the lowest-index set bit of sel.
  - Else: blank.
- **Blank display:** secs=0, mins=0, led all ones, cur_ch=0, valid=0.
- **Displayed channel k:** secs and mins come from channel k. led[k]=0 and all other led bits are 1. cur_ch=k, valid=1.
- **Freeze:** while freeze=1, secs, mins, led, cur_ch and valid do not update. Scan state keeps running. When freeze falls, outputs take the current selection on the next edge.
- **Scan state:** tick counter tcnt (0..SCAN_TICKS-1) and scan_idx (0..NCH-1).
  - Both count only when scan_en=1 and hold=0.
  - If tcnt = SCAN_TICKS-1: tcnt goes to 0 and scan_idx increments, wrapping NCH-1 to 0. Otherwise tcnt increments.
  - When scan_en=0, tcnt and scan_idx clear to 0 on the next edge.
  - While hold=1 and scan_en=1, both keep their values (pause). Scanning resumes where it stopped once hold is released.
  - SCAN_TICKS=1 advances scan_idx on every counting cycle.
- **Simultaneous inputs:** hold overrides scan and sel. Scan overrides sel. The sel contents are ignored while hold or scan is active.
- **Input sampling:** channel data is sampled every cycle (live display). Only freeze holds the values.

## Timing
- **Latency:** one cycle. Inputs sampled at edge n appear on the outputs after edge n.
- **Reset (asynchronous, rst_n=0):** secs=0, mins=0, led all ones, cur_ch=0, valid=0, tcnt=0, scan_idx=0. Release is synchronous to clk in the surrounding design.
- **Scan start:** with scan_en rising at edge 0 from cleared state, channel 0 is displayed after edge 1. Each channel is shown for SCAN_TICKS cycles. The sequence wraps 0,1,…,NCH-1,0.
- **Reset mid-scan:** returns to blank output and scan_idx=0. The scan restarts at channel 0.

## Test plan
Defaults: NCH=4, W=8, SCAN_TICKS=4. Channel k carries secs=8'h10+k and mins=8'h20+k.
- **Reset:** rst_n=0 during activity -> immediately secs=0, mins=0, led=4'b1111, valid=0, cur_ch=0.
- **Direct select:** sel=4'b0110 -> next cycle secs=8'h11, mins=8'h21, led=4'b1101, cur_ch=1. Then sel=0 -> blank.
- **Hold:** hold=1, hold_ch=3, sel=4'b0001, scan_en=1 -> secs=8'h13, led=4'b0111. Scan counters stay constant. Then hold=0 -> scan resumes from the paused index.
- **Scan wrap:** scan_en=1 for 20 cycles -> cur_ch sequence 0,1,2,3,0, each held exactly 4 cycles. scan_en=0 -> scan_idx=0 next cycle.
- **Freeze:** show channel 2, set freeze=1, change inputs and sel -> outputs remain secs=8'h12, led=4'b1011. Release freeze -> new selection after one cycle.
- **Invalid hold index:** NCH=3 (CHW=2), hold=1, hold_ch=3 -> blank output, led=3'b111, valid=0.

Source files
------------

// File: rtl/timer_disp_sel.sv
// N-channel display selector: hold > round-robin scan > direct select, with
// registered outputs that can be frozen for lap display.
module timer_disp_sel #(
  parameter  int NCH        = 4,
  parameter  int W          = 8,
  parameter  int SCAN_TICKS = 4,
  localparam int CHW        = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   secs_in,
  input  logic [NCH*W-1:0]   mins_in,
  input  logic [NCH-1:0]     sel,
  input  logic               hold,
  input  logic [CHW-1:0]     hold_ch,
  input  logic               scan_en,
  input  logic               freeze,
  output logic [W-1:0]       secs,
  output logic [W-1:0]       mins,
  output logic [NCH-1:0]     led,
  output logic [CHW-1:0]     cur_ch,
  output logic               valid
);

  localparam int          TW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned NCH_U = NCH;

  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [CHW-1:0] scan_idx_q, scan_idx_d;
  logic [W-1:0]   secs_q, secs_d, mins_q, mins_d;
  logic [NCH-1:0] led_q, led_d;
  logic [CHW-1:0] cur_ch_q, cur_ch_d;
  logic           valid_q, valid_d;

  logic           show;
  logic [CHW-1:0] ch;

  // Channel choice by priority; an out-of-range hold index blanks the display.
  always_comb begin
    show = 1'b0;
    ch   = '0;
    if (hold) begin
      if (32'(hold_ch) < NCH_U) begin
        show = 1'b1;
        ch   = hold_ch;
      end
    end else if (scan_en) begin
      show = 1'b1;
      ch   = scan_idx_q;
    end else begin
      for (int unsigned k = 0; k < NCH_U; k++) begin
        if (sel[k] && !show) begin
          show = 1'b1;
          ch   = CHW'(k);
        end
      end
    end
  end

  // Scan counters pause under hold and clear whenever scan is disabled.
  always_comb begin
    tcnt_d     = tcnt_q;
    scan_idx_d = scan_idx_q;
    if (!scan_en) begin
      tcnt_d     = '0;
      scan_idx_d = '0;
    end else if (!hold) begin
      if (tcnt_q == TW'(SCAN_TICKS - 1)) begin
        tcnt_d     = '0;
        scan_idx_d = (scan_idx_q == CHW'(NCH - 1)) ? '0 : scan_idx_q + CHW'(1);
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    secs_d   = secs_q;
    mins_d   = mins_q;
    led_d    = led_q;
    cur_ch_d = cur_ch_q;
    valid_d  = valid_q;
    if (!freeze) begin
      secs_d   = '0;
      mins_d   = '0;
      led_d    = '1;
      cur_ch_d = '0;
      valid_d  = 1'b0;
      if (show) begin
        secs_d   = secs_in[ch*W +: W];
        mins_d   = mins_in[ch*W +: W];
        led_d    = ~(NCH'(1) << ch);
        cur_ch_d = ch;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q     <= '0;
      scan_idx_q <= '0;
      secs_q     <= '0;
      mins_q     <= '0;
      led_q      <= '1;
      cur_ch_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      scan_idx_q <= scan_idx_d;
      secs_q     <= secs_d;
      mins_q     <= mins_d;
      led_q      <= led_d;
      cur_ch_q   <= cur_ch_d;
      valid_q    <= valid_d;
    end
  end

  assign secs   = secs_q;
  assign mins   = mins_q;
  assign led    = led_q;
  assign cur_ch = cur_ch_q;
  assign valid  = valid_q;

endmodule
